// File: rtl/instruction_fetch_stage_if.sv
// Bundles the fetch stage's control inputs, its instruction-memory port and
// the IF/ID pipeline register outputs.
// The master side is the fetch stage, because it originates InstructionAddress.
// The slave side is the surrounding datapath: memory, hazard unit and decode.
interface instruction_fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            Stall;
   logic            Flush;
   logic            BranchTaken;
   logic [XLEN-1:0] BranchTarget;
   logic [XLEN-1:0] ReadInstruction;
   logic [XLEN-1:0] InstructionAddress;
   logic [XLEN-1:0] IF_ID_PC;
   logic [XLEN-1:0] IF_ID_PCPlus4;
   logic [XLEN-1:0] IF_ID_Instruction;
   logic            IF_ID_Valid;
   logic            FetchFault;
   logic [31:0]     FetchCount;

   modport master (
      input  Stall, Flush, BranchTaken, BranchTarget, ReadInstruction,
      output InstructionAddress, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Instruction,
             IF_ID_Valid, FetchFault, FetchCount
   );

   modport slave (
      output Stall, Flush, BranchTaken, BranchTarget, ReadInstruction,
      input  InstructionAddress, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Instruction,
             IF_ID_Valid, FetchFault, FetchCount
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// RV32I instruction fetch stage.
// It owns the program counter and drives it straight to InstructionMemory.
// The next PC comes from either the sequential increment or a branch/jump
// redirect, with the redirect taking priority.
// The combinational instruction is captured into the IF/ID register, which
// supports stall, flush and bubble insertion.
module instruction_fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      reset,
   instruction_fetch_stage_if.master bus
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pcPlus4;
   logic [XLEN-1:0] ifIdPc_q, ifIdPc_d;
   logic [XLEN-1:0] ifIdPcPlus4_q, ifIdPcPlus4_d;
   logic [XLEN-1:0] ifIdInstr_q, ifIdInstr_d;
   logic            ifIdValid_q, ifIdValid_d;
   logic            fault_q, fault_d;
   logic [31:0]     count_q, count_d;
   logic            bubble;
   logic            loadSlot;

   // A redirect always inserts a bubble, because the instruction fetched this
   // cycle lies on the wrong path.
   // Only a real load into IF/ID counts as a fetched instruction.
   assign pcPlus4  = pc_q + XLEN'(4);
   assign bubble   = bus.Flush | bus.BranchTaken;
   assign loadSlot = ~bubble & ~bus.Stall;

   // Next-PC selection: a redirect beats a stall, and a stall beats the sequential increment.
   always_comb begin
      pc_d = pcPlus4;
      if (bus.BranchTaken) begin
         pc_d = {bus.BranchTarget[XLEN-1:2], 2'b00};
      end else if (bus.Stall) begin
         pc_d = pc_q;
      end
   end

   // IF/ID next state.
   // A bubble keeps the old PC fields and only kills the instruction.
   // A stall freezes every field.
   always_comb begin
      ifIdPc_d      = ifIdPc_q;
      ifIdPcPlus4_d = ifIdPcPlus4_q;
      ifIdInstr_d   = ifIdInstr_q;
      ifIdValid_d   = ifIdValid_q;
      if (bubble) begin
         ifIdInstr_d = NOP_INSTR;
         ifIdValid_d = 1'b0;
      end else if (!bus.Stall) begin
         ifIdPc_d      = pc_q;
         ifIdPcPlus4_d = pcPlus4;
         ifIdInstr_d   = bus.ReadInstruction;
         ifIdValid_d   = 1'b1;
      end
   end

   // Sticky misaligned-redirect flag and the accepted-instruction counter.
   always_comb begin
      fault_d = fault_q | (bus.BranchTaken & (bus.BranchTarget[1:0] != 2'b00));
      count_d = count_q + {31'd0, loadSlot};
   end

   // State registers; reset discards any in-flight instruction immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         ifIdPc_q      <= '0;
         ifIdPcPlus4_q <= '0;
         ifIdInstr_q   <= NOP_INSTR;
         ifIdValid_q   <= 1'b0;
         fault_q       <= 1'b0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         ifIdPc_q      <= ifIdPc_d;
         ifIdPcPlus4_q <= ifIdPcPlus4_d;
         ifIdInstr_q   <= ifIdInstr_d;
         ifIdValid_q   <= ifIdValid_d;
         fault_q       <= fault_d;
         count_q       <= count_d;
      end
   end

   assign bus.InstructionAddress = pc_q;
   assign bus.IF_ID_PC           = ifIdPc_q;
   assign bus.IF_ID_PCPlus4      = ifIdPcPlus4_q;
   assign bus.IF_ID_Instruction  = ifIdInstr_q;
   assign bus.IF_ID_Valid        = ifIdValid_q;
   assign bus.FetchFault         = fault_q;
   assign bus.FetchCount         = count_q;

endmodule
